// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, shift opcodes and the shifter FSM encoding.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  localparam logic OP_SLL = 1'b0;
  localparam logic OP_ROL = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/mux2_1.sv
// Single-bit 2:1 multiplexer cell; y follows b when sel is high.
module mux2_1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/shift_left_stage.sv
// One log-shifter stage: conditionally shifts/rotates left by 2^k.
// The final bypass-or-shift choice is a row of mux2_1 cells.
module shift_left_stage
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        k,
  input  logic              en,
  input  logic              op,
  output logic [DATA_W-1:0] dout
);

  logic [4:0]        amt;
  logic [DATA_W-1:0] shl;
  logic [DATA_W-1:0] wrap;
  logic [DATA_W-1:0] shifted;

  // The wrap term brings bits pushed past the MSB back in at the bottom;
  // zero fill simply drops it.
  always_comb begin
    amt     = 5'd1 << k;
    shl     = din << amt;
    wrap    = din >> (5'(DATA_W) - amt);
    shifted = (op == OP_ROL) ? (shl | wrap) : shl;
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    mux2_1 u_mux (
      .a  (din[i]),
      .b  (shifted[i]),
      .sel(en),
      .y  (dout[i])
    );
  end

endmodule

// File: rtl/shift_left_seq.sv
// Multi-cycle 16-bit left shifter/rotator: one log-shift stage per clock,
// with a start/busy/done handshake for the execute-stage controller.
module shift_left_seq
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] A,
  input  logic [CNT_W-1:0]  Cnt,
  input  logic              Op,
  output logic [DATA_W-1:0] Out,
  output logic              busy,
  output logic              done
);

  state_t            state_q;
  state_t            state_d;
  logic [1:0]        stage_q;
  logic [DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              op_q;
  logic [DATA_W-1:0] out_q;
  logic              busy_q;
  logic              done_q;

  logic              load;
  logic              step;
  logic              last;
  logic [DATA_W-1:0] stage_out;

  shift_left_stage u_stage (
    .din (acc_q),
    .k   (stage_q),
    .en  (cnt_q[stage_q]),
    .op  (op_q),
    .dout(stage_out)
  );

  // NOTE: every output of a combinational block gets a default before the
  // case statement; a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        step = 1'b1;
        if (stage_q == 2'd3) begin
          last    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the reset clears all of it, including acc/cnt/op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stage_q <= 2'd0;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SLL;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last;
      if (load) begin
        acc_q   <= A;
        cnt_q   <= Cnt;
        op_q    <= Op;
        stage_q <= 2'd0;
        busy_q  <= 1'b1;
      end
      // The 2-bit stage counter wraps back to 0 on the completing edge.
      if (step) begin
        acc_q   <= stage_out;
        stage_q <= stage_q + 2'd1;
      end
      if (last) begin
        out_q  <= stage_out;
        busy_q <= 1'b0;
      end
    end
  end

  assign Out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_shift_left_seq.sv
// Directed bench for shift_left_seq: hand-computed results, handshake timing,
// ignored restarts, back-to-back issue and mid-operation reset.
module tb_shift_left_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [3:0]  Cnt;
  logic        Op;
  logic [15:0] Out;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  logic [15:0] prev_out;

  shift_left_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .Cnt  (Cnt),
    .Op   (Op),
    .Out  (Out),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of cycle 0; returns at the negedge of cycle 6.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [3:0] c,
                       input logic o, input logic [15:0] exp);
    A = a; Cnt = c; Op = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check({tag, "_busy"}, {15'd0, busy}, 16'd1);
      check({tag, "_nodone"}, {15'd0, done}, 16'd0);
      check({tag, "_hold"}, Out, prev_out);
      @(negedge clk);
    end
    check({tag, "_done"}, {15'd0, done}, 16'd1);
    check({tag, "_idle"}, {15'd0, busy}, 16'd0);
    check({tag, "_out"}, Out, exp);
    prev_out = exp;
    @(negedge clk);
    check({tag, "_pulse"}, {15'd0, done}, 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; A = '0; Cnt = '0; Op = 1'b0;
    prev_out = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_out", Out, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("sll_1_f",    16'h0001, 4'hF, 1'b0, 16'h8000);
    do_op("rol_8001_1", 16'h8001, 4'h1, 1'b1, 16'h0003);
    do_op("sll_8001_1", 16'h8001, 4'h1, 1'b0, 16'h0002);
    do_op("sll_abcd_4", 16'hABCD, 4'h4, 1'b0, 16'hBCD0);
    do_op("rol_abcd_4", 16'hABCD, 4'h4, 1'b1, 16'hBCDA);
    do_op("rol_abcd_8", 16'hABCD, 4'h8, 1'b1, 16'hCDAB);
    do_op("sll_1234_0", 16'h1234, 4'h0, 1'b0, 16'h1234);
    do_op("rol_1234_0", 16'h1234, 4'h0, 1'b1, 16'h1234);
    do_op("rol_8000_f", 16'h8000, 4'hF, 1'b1, 16'h4000);
    do_op("sll_00ff_5", 16'h00FF, 4'h5, 1'b0, 16'h1FE0);
    do_op("rol_ff00_c", 16'hFF00, 4'hC, 1'b1, 16'h0FF0);

    // Restart attempts in cycles 2-3 are ignored; start in the done cycle is taken.
    A = 16'h00F0; Cnt = 4'h4; Op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 16'hFFFF; Cnt = 4'h1; Op = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    check("ign_busy4", {15'd0, busy}, 16'd1);
    @(negedge clk);
    check("ign_done5", {15'd0, done}, 16'd1);
    check("ign_out", Out, 16'h0F00);
    A = 16'h0003; Cnt = 4'h2; Op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 6; i <= 9; i++) begin
      check("b2b_busy", {15'd0, busy}, 16'd1);
      check("b2b_nodone", {15'd0, done}, 16'd0);
      check("b2b_hold", Out, 16'h0F00);
      @(negedge clk);
    end
    check("b2b_done10", {15'd0, done}, 16'd1);
    check("b2b_out", Out, 16'h000C);
    @(negedge clk);
    check("b2b_pulse", {15'd0, done}, 16'd0);
    check("b2b_idle", {15'd0, busy}, 16'd0);

    // Reset in cycle 2 of an operation aborts it and clears Out.
    A = 16'h1234; Cnt = 4'h1; Op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", {15'd0, busy}, 16'd0);
    for (int i = 3; i <= 10; i++) begin
      check("abort_nodone", {15'd0, done}, 16'd0);
      check("abort_out", Out, 16'h0000);
      @(negedge clk);
    end
    check("abort_idle", {15'd0, busy}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
